// File: rtl/ritc_word_serializer_pkg.sv
// Shared definitions for the RITC word serializer: control register bit
// positions, word/beat geometry and the serializer state enumeration.
package ritc_word_serializer_pkg;

    // Control register bit positions (user_dat_i / user_dat_o)
    localparam int unsigned CTRL_ENABLE  = 0;
    localparam int unsigned CTRL_TRAIN   = 1;
    localparam int unsigned CTRL_PAT_LSB = 4;
    localparam int unsigned CTRL_CLR     = 31;

    // Word geometry
    localparam int unsigned BEATS_PER_WORD = 4;
    localparam int unsigned BEAT_W         = 12;
    localparam int unsigned WORD_W         = BEATS_PER_WORD * BEAT_W;
    localparam int unsigned SHREG_W        = (BEATS_PER_WORD - 1) * BEAT_W;
    localparam int unsigned CNT_W          = 2;
    localparam int unsigned UCNT_W         = 16;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_RUN,
        ST_TRAIN
    } state_t;

endpackage

// File: rtl/ritc_word_serializer_if.sv
// Word handshake and user register bus of the RITC word serializer.
interface ritc_word_serializer_if;
    import ritc_word_serializer_pkg::*;

    logic [WORD_W-1:0] word_i;
    logic              word_valid_i;
    logic              word_ready_o;
    logic              user_sel_i;
    logic              user_wr_i;
    logic [31:0]       user_dat_i;
    logic [31:0]       user_dat_o;

    modport master (
        output word_i, word_valid_i, user_sel_i, user_wr_i, user_dat_i,
        input  word_ready_o, user_dat_o
    );

    modport slave (
        input  word_i, word_valid_i, user_sel_i, user_wr_i, user_dat_i,
        output word_ready_o, user_dat_o
    );

endinterface

// File: rtl/ritc_word_serializer.sv
// RITC word serializer: turns 48-bit words into four registered 12-bit beats
// per word, with a training mode, a single-entry input buffer and an
// underflow counter visible through the user register.
module ritc_word_serializer
    import ritc_word_serializer_pkg::*;
#(
    parameter logic [BEAT_W-1:0] IDLE_PATTERN  = 12'h000,
    parameter logic [BEAT_W-1:0] TRAIN_DEFAULT = 12'hA5C
) (
    input  logic                  SYSCLK,
    input  logic                  rst_n_i,
    ritc_word_serializer_if.slave bus,
    output logic [BEAT_W-1:0]     dout_o,
    output logic                  frame_o
);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [WORD_W-1:0]   word_buf;
    logic                buf_valid;
    logic [SHREG_W-1:0]  shreg;
    logic                enable;
    logic                train;
    logic [BEAT_W-1:0]   train_pattern;
    logic [UCNT_W-1:0]   underflow_cnt;

    logic                user_write;
    logic                accept;
    logic                end_of_word;
    logic                run_start;
    logic                underflow;
    logic                ctrl_unused;

    assign user_write  = bus.user_sel_i & bus.user_wr_i;
    assign accept      = bus.word_valid_i & bus.word_ready_o;
    assign end_of_word = (cnt == CNT_W'(BEATS_PER_WORD - 1));
    assign run_start   = (state == ST_RUN) && (cnt == '0);
    assign underflow   = run_start && !buf_valid;
    assign ctrl_unused = ^{bus.user_dat_i[30:16], bus.user_dat_i[3:2]};

    // State register
    always_ff @(posedge SYSCLK or negedge rst_n_i) begin
        if (!rst_n_i) state <= ST_OFF;
        else          state <= state_nxt;
    end

    // Next state: only re-evaluated at end of word, or on any cycle in OFF
    always_comb begin
        state_nxt = state;
        if (state == ST_OFF || end_of_word) begin
            if (!enable)    state_nxt = ST_OFF;
            else if (train) state_nxt = ST_TRAIN;
            else            state_nxt = ST_RUN;
        end
    end

    // Ready: free buffer slot, or the slot is being drained this cycle
    always_comb begin
        bus.word_ready_o = 1'b0;
        if (state != ST_OFF)
            bus.word_ready_o = !buf_valid || run_start;
    end

    // Beat counter: free-running in RUN/TRAIN, parked at 0 in OFF
    always_ff @(posedge SYSCLK or negedge rst_n_i) begin
        if (!rst_n_i)             cnt <= '0;
        else if (state == ST_OFF) cnt <= '0;
        else                      cnt <= cnt + CNT_W'(1);
    end

    // Single-entry input buffer: flushed in OFF, drained at RUN word start
    always_ff @(posedge SYSCLK or negedge rst_n_i) begin
        if (!rst_n_i) begin
            word_buf  <= '0;
            buf_valid <= 1'b0;
        end else if (state == ST_OFF) begin
            buf_valid <= 1'b0;
        end else if (accept) begin
            word_buf  <= bus.word_i;
            buf_valid <= 1'b1;
        end else if (run_start) begin
            buf_valid <= 1'b0;
        end
    end

    // Beat datapath: word start loads the shift register (or idle fill on
    // underflow), later beats shift it out low slice first
    always_ff @(posedge SYSCLK or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dout_o  <= IDLE_PATTERN;
            frame_o <= 1'b0;
            shreg   <= '0;
        end else begin
            case (state)
                ST_TRAIN: begin
                    dout_o  <= train_pattern;
                    frame_o <= (cnt == '0);
                end
                ST_RUN: begin
                    if (cnt == '0) begin
                        frame_o <= 1'b1;
                        if (buf_valid) begin
                            dout_o <= word_buf[BEAT_W-1:0];
                            shreg  <= word_buf[WORD_W-1:BEAT_W];
                        end else begin
                            dout_o <= IDLE_PATTERN;
                            shreg  <= {(BEATS_PER_WORD - 1){IDLE_PATTERN}};
                        end
                    end else begin
                        frame_o <= 1'b0;
                        dout_o  <= shreg[BEAT_W-1:0];
                        shreg   <= {IDLE_PATTERN, shreg[SHREG_W-1:BEAT_W]};
                    end
                end
                default: begin
                    dout_o  <= IDLE_PATTERN;
                    frame_o <= 1'b0;
                end
            endcase
        end
    end

    // Control registers and saturating underflow counter; clear beats increment
    always_ff @(posedge SYSCLK or negedge rst_n_i) begin
        if (!rst_n_i) begin
            enable        <= 1'b0;
            train         <= 1'b0;
            train_pattern <= TRAIN_DEFAULT;
            underflow_cnt <= '0;
        end else begin
            if (user_write) begin
                enable        <= bus.user_dat_i[CTRL_ENABLE];
                train         <= bus.user_dat_i[CTRL_TRAIN];
                train_pattern <= bus.user_dat_i[CTRL_PAT_LSB +: BEAT_W];
            end
            if (user_write && bus.user_dat_i[CTRL_CLR])
                underflow_cnt <= '0;
            else if (underflow && underflow_cnt != '1)
                underflow_cnt <= underflow_cnt + UCNT_W'(1);
        end
    end

    // Register readback, side-effect free
    always_comb begin
        bus.user_dat_o = {underflow_cnt, train_pattern, 2'b00, train, enable};
    end

endmodule

// File: tb/tb_ritc_word_serializer.sv
// Self-checking bench for ritc_word_serializer against a queue-based
// behavioural model of the word/beat rules.
module tb_ritc_word_serializer;

    localparam logic [11:0] IDLE = 12'h000;
    localparam int MOFF   = 0;
    localparam int MRUN   = 1;
    localparam int MTRAIN = 2;

    logic        SYSCLK;
    logic        rst_n_i;
    logic [11:0] dout_o;
    logic        frame_o;

    ritc_word_serializer_if bus();

    ritc_word_serializer #(
        .IDLE_PATTERN (IDLE),
        .TRAIN_DEFAULT(12'hA5C)
    ) dut (
        .SYSCLK (SYSCLK),
        .rst_n_i(rst_n_i),
        .bus    (bus),
        .dout_o (dout_o),
        .frame_o(frame_o)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    int compared = 0;
    int mism     = 0;

    // Reference model: word-level view with queues
    int          m_mode;
    int          m_beat;
    logic [47:0] m_bufq[$];
    logic [11:0] m_outq[$];
    logic        m_en;
    logic        m_tr;
    logic [11:0] m_pat;
    int unsigned m_ucnt;
    logic [11:0] e_dout;
    logic        e_frame;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] rnd48();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[47:0];
    endfunction

    function automatic logic m_ready();
        if (m_mode == MOFF) return 1'b0;
        return (m_bufq.size() == 0) || (m_mode == MRUN && m_beat == 0);
    endfunction

    function automatic logic [31:0] exp_ud();
        logic [15:0] u;
        u = 16'(m_ucnt);
        return {u, m_pat, 2'b00, m_tr, m_en};
    endfunction

    task automatic model_reset();
        m_mode = MOFF;
        m_beat = 0;
        m_bufq.delete();
        m_outq.delete();
        m_en = 1'b0;
        m_tr = 1'b0;
        m_pat = 12'hA5C;
        m_ucnt = 0;
        e_dout = IDLE;
        e_frame = 1'b0;
    endtask

    task automatic model_step();
        logic        acc;
        logic        wr;
        int          old_mode;
        logic [47:0] w;
        acc = bus.word_valid_i && m_ready();
        wr = bus.user_sel_i && bus.user_wr_i;
        old_mode = m_mode;
        if (m_mode == MOFF) begin
            e_dout = IDLE;
            e_frame = 1'b0;
            m_bufq.delete();
            m_outq.delete();
        end else if (m_mode == MTRAIN) begin
            e_dout = m_pat;
            e_frame = (m_beat == 0);
        end else begin
            if (m_beat == 0) begin
                e_frame = 1'b1;
                m_outq.delete();
                if (m_bufq.size() > 0) begin
                    w = m_bufq.pop_front();
                    for (int k = 0; k < 4; k++) m_outq.push_back(w[12*k +: 12]);
                end else begin
                    for (int k = 0; k < 4; k++) m_outq.push_back(IDLE);
                    if (m_ucnt < 65535) m_ucnt++;
                end
            end else begin
                e_frame = 1'b0;
            end
            e_dout = m_outq.pop_front();
        end
        if (acc) m_bufq.push_back(bus.word_i);
        if (old_mode == MOFF || m_beat == 3)
            m_mode = !m_en ? MOFF : (m_tr ? MTRAIN : MRUN);
        m_beat = (old_mode == MOFF) ? 0 : (m_beat + 1) % 4;
        if (wr) begin
            m_en = bus.user_dat_i[0];
            m_tr = bus.user_dat_i[1];
            m_pat = bus.user_dat_i[15:4];
            if (bus.user_dat_i[31]) m_ucnt = 0;
        end
    endtask

    // One clock: check comb outputs, step model on the edge, check registered outputs
    task automatic tick();
        chk("ready", 32'(bus.word_ready_o), 32'(m_ready()));
        chk("user_dat", bus.user_dat_o, exp_ud());
        @(posedge SYSCLK);
        model_step();
        #1;
        chk("dout", 32'(dout_o), 32'(e_dout));
        chk("frame", 32'(frame_o), 32'(e_frame));
        @(negedge SYSCLK);
    endtask

    task automatic user_write(input logic [31:0] d);
        bus.user_sel_i = 1'b1;
        bus.user_wr_i = 1'b1;
        bus.user_dat_i = d;
        tick();
        bus.user_sel_i = 1'b0;
        bus.user_wr_i = 1'b0;
        bus.user_dat_i = '0;
    endtask

    task automatic run(input int n, input int valid_pct);
        for (int i = 0; i < n; i++) begin
            bus.word_i = rnd48();
            bus.word_valid_i = ($urandom_range(99) < valid_pct);
            tick();
        end
    endtask

    initial begin
        int n;
        rst_n_i = 1'b0;
        bus.word_i = '0;
        bus.word_valid_i = 1'b0;
        bus.user_sel_i = 1'b0;
        bus.user_wr_i = 1'b0;
        bus.user_dat_i = '0;
        model_reset();
        #12;
        chk("rst_dout", 32'(dout_o), 32'(IDLE));
        chk("rst_frame", 32'(frame_o), 32'd0);
        chk("rst_ready", 32'(bus.word_ready_o), 32'd0);
        chk("rst_user_dat", bus.user_dat_o, 32'h0000_A5C0);
        @(negedge SYSCLK);
        rst_n_i = 1'b1;
        tick();

        // Enable, fixed word presented continuously
        user_write(32'h0000_0001);
        bus.word_valid_i = 1'b1;
        bus.word_i = 48'h3332_2211_1000;
        for (int i = 0; i < 24; i++) tick();

        // Random words, random valid
        run(60, 70);

        // Starve the input for 8 cycles, then resume
        bus.word_valid_i = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        run(12, 100);

        // Switch to training mid-word, then back to run
        n = 0;
        while (!(m_mode == MRUN && m_beat == 1) && n < 16) begin
            bus.word_i = rnd48();
            tick();
            n++;
        end
        chk("wait_midword", 32'(n >= 16), 32'd0);
        user_write(32'h0000_5A73);
        run(16, 100);
        bus.word_valid_i = 1'b0;
        user_write(32'h0000_0001);
        run(16, 60);

        // Underflow counter saturation and clear on an underflow edge
        bus.word_valid_i = 1'b0;
        force dut.underflow_cnt = 16'hFFFD;
        #1;
        release dut.underflow_cnt;
        m_ucnt = 32'hFFFD;
        for (int i = 0; i < 20; i++) tick();
        n = 0;
        while (!(m_mode == MRUN && m_beat == 0 && m_bufq.size() == 0) && n < 16) begin
            tick();
            n++;
        end
        chk("wait_underflow_edge", 32'(n >= 16), 32'd0);
        user_write(32'h8000_0001);
        for (int i = 0; i < 6; i++) tick();

        // Reset asserted at beat 2 of a word
        bus.word_valid_i = 1'b1;
        n = 0;
        while (!(m_mode == MRUN && m_beat == 2) && n < 16) begin
            bus.word_i = rnd48();
            tick();
            n++;
        end
        chk("wait_cnt2", 32'(n >= 16), 32'd0);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("midrst_dout", 32'(dout_o), 32'(IDLE));
        chk("midrst_ready", 32'(bus.word_ready_o), 32'd0);
        chk("midrst_frame", 32'(frame_o), 32'd0);
        model_reset();
        @(posedge SYSCLK);
        @(negedge SYSCLK);
        rst_n_i = 1'b1;
        run(8, 100);
        user_write(32'h0000_0001);
        run(16, 100);

        // Disable while a word is buffered, then re-enable
        n = 0;
        while (!(m_bufq.size() == 1 && m_beat == 1) && n < 32) begin
            bus.word_i = rnd48();
            bus.word_valid_i = 1'b1;
            tick();
            n++;
        end
        chk("wait_buffered", 32'(n >= 32), 32'd0);
        bus.word_valid_i = 1'b0;
        user_write(32'h0000_0000);
        for (int i = 0; i < 10; i++) tick();
        user_write(32'h0000_0001);
        run(24, 80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
